// File: rtl/apb_master_if.sv
// apb_master_if: local command/response port plus APB bus signals between apb_master and a slave.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PRWADDR;
    logic [DATA_W-1:0] PRWDATA;
    logic [DATA_W-1:0] PRWDATA1;
    logic              PREADY;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRWDATA1, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRWDATA1, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-command APB requester (IDLE -> SETUP -> ACCESS) with registered outputs.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t            r_state, w_state;
    logic              r_ready, w_ready;
    logic              r_rsp_valid, w_rsp_valid;
    logic              r_rsp_err, w_rsp_err;
    logic              r_psel, w_psel;
    logic              r_penable, w_penable;
    logic              r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              w_abort;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]     r_cnt, w_cnt;
`endif
    always_comb begin
        w_state     = r_state;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rdata     = r_rdata;
        w_abort     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        w_cnt       = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                // r_ready is low for one IDLE cycle after a response, giving the mandatory gap
                if (bus.req_valid && r_ready) begin
                    w_state  = SETUP;
                    w_psel   = 1'b1;
                    w_pwrite = bus.req_write;
                    w_addr   = bus.req_addr;
                    w_wdata  = bus.req_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    w_cnt    = '0;
`endif
                end else begin
                    w_ready = 1'b1;
                end
            end
            SETUP: begin
                w_state   = ACCESS;
                w_penable = 1'b1;
            end
            ACCESS: begin
`ifdef APB_MASTER_TIMEOUT_EN
                w_abort = !bus.PREADY && r_cnt == CW'(TIMEOUT_CYCLES - 1);
                w_cnt   = bus.PREADY ? r_cnt : r_cnt + 1'b1;
`endif
                if (bus.PREADY || w_abort) begin
                    w_state     = IDLE;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = w_abort;
                    w_rdata     = w_abort ? '0 : r_pwrite ? r_rdata : bus.PRWDATA1;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rdata     <= w_rdata;
        end
    end
`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) r_cnt <= '0;
        else        r_cnt <= w_cnt;
    end
    assign bus.rsp_err = r_rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif
    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PRWADDR   = r_addr;
    assign bus.PRWDATA   = r_wdata;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized bench for apb_master; a cycle-indexed transaction model predicts every output each cycle.
`timescale 1ns/1ps
module tb_apb_master;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
    always #5 PCLK = ~PCLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit busy = 1'b0, m_err = 1'b0;
    int k = 0, w = 0, last = 0, n_acc = 0;
    logic [31:0] t_rd = '0;
    logic e_rdy = 1'b0, e_rv = 1'b0, e_err = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_pw = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, want);
        end
    endtask

    task automatic check_all();
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("PSEL", 32'(bus.PSEL), 32'(e_psel));
        chk("PENABLE", 32'(bus.PENABLE), 32'(e_pen));
        chk("PWRITE", 32'(bus.PWRITE), 32'(e_pw));
        chk("PRWADDR", bus.PRWADDR, e_addr);
        chk("PRWDATA", bus.PRWDATA, e_wdata);
    endtask

    // Transaction view: k counts cycles since acceptance (1 = SETUP), the slave answers at k = w + 2.
    task automatic step(input bit rst, input bit v, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int wt, input logic [31:0] rd);
        PRESET = rst;
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_addr = a;
        bus.req_wdata = d;
        bus.PREADY = (busy && k >= 2) ? (k == w + 2) : (busy && k == 1) ? 1'b1 : 1'($urandom);
        bus.PRWDATA1 = (busy && k == w + 2) ? t_rd : $urandom;
        e_rv = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            busy = 1'b0;
            {e_rdy, e_psel, e_pen, e_pw} = '0;
            e_addr = '0;
            e_wdata = '0;
            e_rdata = '0;
        end else if (busy && k == last) begin
            busy = 1'b0;
            e_rv = 1'b1;
            e_err = m_err;
            e_rdata = m_err ? 32'h0 : e_pw ? e_rdata : t_rd;
            e_psel = 1'b0;
            e_pen = 1'b0;
            e_rdy = 1'b0;
        end else if (busy) begin
            k++;
            e_pen = 1'b1;
        end else if (e_rdy && v) begin
            busy = 1'b1;
            k = 1;
            w = wt;
            t_rd = rd;
`ifdef APB_MASTER_TIMEOUT_EN
            m_err = (w >= TO);
            last = m_err ? TO + 1 : w + 2;
`else
            m_err = 1'b0;
            last = w + 2;
`endif
            e_psel = 1'b1;
            e_pen = 1'b0;
            e_pw = wr;
            e_addr = a;
            e_wdata = d;
            e_rdy = 1'b0;
            n_acc++;
        end else begin
            e_rdy = 1'b1;
        end
        @(negedge PCLK);
        cyc++;
        check_all();
    endtask

    initial begin
        int a_e, e1, e2, n_rsp;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.PREADY = 1'b0;
        bus.PRWDATA1 = '0;
        @(negedge PCLK);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_addr", bus.PRWADDR, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready_rise", 32'(bus.req_ready), 32'd1);

        step(0, 1, 1, 32'h4, 32'hA, 1, 0);
        a_e = cyc;
        chk("wr_setup_psel", 32'(bus.PSEL), 32'd1);
        chk("wr_setup_pen", 32'(bus.PENABLE), 32'd0);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (bus.PSEL) chk("wr_addr_stable", bus.PRWADDR, 32'h4);
            if (bus.PSEL) chk("wr_data_stable", bus.PRWDATA, 32'hA);
        end
        chk("wr_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("wr_latency", 32'(cyc - a_e), 32'd3);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wr_pulse_once", 32'(bus.rsp_valid), 32'd0);

        step(0, 1, 0, 32'h4, 32'h0, 3, 32'hDEAD_BEEF);
        a_e = cyc;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("rd_data", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_latency", 32'(cyc - a_e), 32'd5);
        step(0, 0, 0, 0, 0, 0, 0);

        a_e = n_acc;
        e1 = -1;
        e2 = -1;
        for (int i = 0; i < 30 && n_acc < a_e + 2; i++) begin
            if (n_acc == a_e) step(0, 1, 1, 32'h4, 32'h5, 1, 0);
            else step(0, 1, 0, 32'h4, 32'h0, 0, 32'h1234_5678);
            if (n_acc == a_e + 1 && e1 < 0) e1 = cyc;
            if (n_acc == a_e + 2 && e2 < 0) e2 = cyc;
        end
        chk("b2b_spacing", 32'(e2 - e1), 32'd5);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("b2b_rd_data", bus.rsp_rdata, 32'h1234_5678);
        chk("b2b_rd_latency", 32'(cyc - e2), 32'd2);
        step(0, 0, 0, 0, 0, 0, 0);

        step(0, 1, 0, 32'h8, 32'h0, 5, 32'h5555_AAAA);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("mid_access_pen", 32'(bus.PENABLE), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_psel", 32'(bus.PSEL), 32'd0);
        chk("mid_rst_pen", 32'(bus.PENABLE), 32'd0);
        n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            n_rsp += int'(bus.rsp_valid);
        end
        chk("mid_rst_no_rsp", 32'(n_rsp), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
        step(0, 1, 0, 32'hC, 32'h0, 100, 32'hFFFF_FFFF);
        a_e = cyc;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("to_err", 32'(bus.rsp_err), 32'd1);
        chk("to_rdata", bus.rsp_rdata, 32'd0);
        chk("to_psel", 32'(bus.PSEL), 32'd0);
        chk("to_latency", 32'(cyc - a_e), 32'd5);
        step(0, 0, 0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom, $urandom, $urandom_range(0, 6), $urandom);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("random_progress", 32'(n_acc > 100), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the same peripheral bus our APB slaves (e.g. the countdown-timer slave) respond on.
- Accepts single read/write commands from a local valid/ready command port and runs the APB sequence IDLE -> SETUP -> ACCESS, waiting on PREADY.
- Returns the read data, or a completion for writes, on a one-cycle response strobe.
- Sits between the system controller / testbench sequencer and one APB slave.

Parameters:
- ADDR_W, 32, width of PRWADDR and req_addr.
- DATA_W, 32, width of PRWDATA, PRWDATA1, req_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY before abort. Used only with APB_MASTER_TIMEOUT_EN.

Ports:
- PCLK  in  1  single clock, rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target register address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- rsp_err  out  1  transfer aborted by timeout; valid with rsp_valid.
- PSEL  out  1  peripheral select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  transfer direction.
- PRWADDR  out  ADDR_W  bus address.
- PRWDATA  out  DATA_W  bus write data.
- PRWDATA1  in  DATA_W  bus read data from slave.
- PREADY  in  1  slave ready.

Behaviour:
- Single clock PCLK. Reset is synchronous and active-high on PRESET.
- Reset: every output register is 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA). The FSM is IDLE and the timeout counter is 0.
- Reset mid-transfer aborts the transfer. No rsp_valid is issued. Bus signals are 0 on the cycle after the reset edge.
- All outputs are registered. No combinational path from an input to an output.
- FSM state IDLE:
  - req_ready = 1.
  - On req_valid, capture req_write, req_addr and req_wdata into PWRITE, PRWADDR and PRWDATA.
  - Set PSEL = 1 and req_ready = 0, then go to SETUP.
- FSM state SETUP:
  - Lasts exactly 1 cycle with PSEL = 1 and PENABLE = 0.
  - Then PENABLE = 1 and go to ACCESS.
- FSM state ACCESS:
  - PSEL = PENABLE = 1, held until PREADY = 1 is sampled.
  - On PREADY, latch rsp_rdata <= PRWDATA1 for reads; rsp_rdata is unchanged for writes.
  - Pulse rsp_valid = 1 with rsp_err = 0, set PSEL = PENABLE = 0, and go to IDLE.
- PREADY is ignored outside ACCESS. Our slaves register PREADY, so it may still be high during the following SETUP.
- PRWADDR, PRWDATA and PWRITE hold stable from SETUP through the end of ACCESS, and retain their values in IDLE.
- Minimum transfer is 3 cycles from acceptance: SETUP, ACCESS, and ACCESS-with-PREADY against a registered-ready slave. A zero-wait slave gives 2 cycles.
- At least one IDLE cycle separates transfers. req_ready rises on the cycle after rsp_valid.
- req_valid arriving while busy is not accepted. The requester must hold it until req_ready.
- rsp_valid is high for exactly 1 cycle per accepted command.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter increments on each ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL = PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and the FSM goes to IDLE.
  - The counter clears on entry to SETUP.
  - If PREADY = 1 arrives on the same cycle the limit is hit, the transfer completes normally with rsp_err = 0.
- Not defined:
  - rsp_err is tied to 0 and no counter exists.
  - ACCESS waits on PREADY indefinitely.

Test Plan:
- Reset: hold PRESET for 2 cycles -> all outputs 0 and req_ready = 1 on the first cycle after reset release.
- Write: req_write = 1, req_addr = 0x4, req_wdata = 0x0000_000A, registered-ready slave model.
  - PSEL = 1 / PENABLE = 0 for 1 cycle, then PENABLE = 1 until PREADY.
  - PRWADDR = 0x4 and PRWDATA = 0xA stable throughout.
  - rsp_valid pulses once with rsp_err = 0.
- Read: slave drives PRWDATA1 = 0xDEAD_BEEF with PREADY after 3 wait cycles -> rsp_valid pulses with rsp_rdata = 0xDEAD_BEEF, exactly 5 cycles after acceptance.
- Back-to-back: req_valid held high for 2 commands (write 0x4 / 0x5, then read 0x4).
  - Second command accepted only after one IDLE cycle.
  - Stale PREADY = 1 during the second SETUP does not complete it early.
- Reset mid-ACCESS: assert PRESET while PENABLE = 1 -> PSEL = PENABLE = 0 next cycle and no rsp_valid.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4): PREADY held 0 -> after 4 ACCESS cycles, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and the bus is idle.
